fec_secded_decoder: RTL and testbench

//  Receive-side FEC block. Decodes one 16-bit encoded message into an 8-bit message.
//  The encoded message is two extended-Hamming (8,4) SECDED codewords.
//  - Single-bit errors are corrected; double-bit errors are flagged.
//  - Sits between the demodulator and the decoder-side circular buffer, under the FEC controller.
//  - Uses the req/ack handshake shared by all pipeline stages.

---
 rtl/fec_secded_decoder.sv | 142 ++++++++++++++
 tb/tb_fec_secded_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fec_secded_decoder.sv
// Receive-side SECDED decoder: two extended-Hamming (8,4) codewords in, one byte out.
// The low codeword is decoded first, then the high one. Saturating counters track corrected and uncorrectable codewords.
module fec_secded_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             req,
    input  logic [15:0]      data_in,
    input  logic             clr_counts,
    output logic             ack,
    output logic [7:0]       data_out,
    output logic             err_corrected,
    output logic             err_uncorrectable,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    typedef enum logic [1:0] {IDLE, DEC_LO, DEC_HI, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_n;
    logic [15:0]      cap_q, cap_n;
    logic [7:0]       data_q, data_n;
    logic             corr_q, corr_n;
    logic             unc_q, unc_n;
    logic             ack_q, ack_n;
    logic [CNT_W-1:0] ccnt_q, ccnt_n;
    logic [CNT_W-1:0] ucnt_q, ucnt_n;
    logic [5:0]       dec_c;

    // Returns {uncorrectable, corrected, d3, d2, d1, d0} for one codeword
    function automatic logic [5:0] decode_cw(input logic [7:0] cw);
        logic [2:0] s;
        logic       p;
        logic [7:0] fixed;
        s[0]  = cw[1] ^ cw[3] ^ cw[5] ^ cw[7];
        s[1]  = cw[2] ^ cw[3] ^ cw[6] ^ cw[7];
        s[2]  = cw[4] ^ cw[5] ^ cw[6] ^ cw[7];
        p     = ^cw;
        fixed = cw;
        if (p && (s != 3'd0)) begin
            fixed[s] = ~cw[s];
        end
        return {(!p) && (s != 3'd0), p, fixed[7], fixed[6], fixed[5], fixed[3]};
    endfunction

    assign dec_c = decode_cw((state_q == DEC_HI) ? cap_q[15:8] : cap_q[7:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= 16'd0;
            data_q  <= 8'd0;
            corr_q  <= 1'b0;
            unc_q   <= 1'b0;
            ack_q   <= 1'b0;
            ccnt_q  <= '0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_n;
            cap_q   <= cap_n;
            data_q  <= data_n;
            corr_q  <= corr_n;
            unc_q   <= unc_n;
            ack_q   <= ack_n;
            ccnt_q  <= ccnt_n;
            ucnt_q  <= ucnt_n;
        end
    end

    always_comb begin
        logic inc_corr;
        logic inc_unc;
        state_n  = state_q;
        cap_n    = cap_q;
        data_n   = data_q;
        corr_n   = corr_q;
        unc_n    = unc_q;
        ack_n    = ack_q;
        inc_corr = 1'b0;
        inc_unc  = 1'b0;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        cap_n   = data_in;
                        state_n = DEC_LO;
                    end
                end
                // Low result overwrites the flags, which clears those of the previous message
                DEC_LO: begin
                    data_n[3:0] = dec_c[3:0];
                    corr_n      = dec_c[4];
                    unc_n       = dec_c[5];
                    inc_corr    = dec_c[4];
                    inc_unc     = dec_c[5];
                    state_n     = DEC_HI;
                end
                DEC_HI: begin
                    data_n[7:4] = dec_c[3:0];
                    corr_n      = corr_q | dec_c[4];
                    unc_n       = unc_q | dec_c[5];
                    inc_corr    = dec_c[4];
                    inc_unc     = dec_c[5];
                    state_n     = DONE;
                end
                DONE: begin
                    if (!ack_q) begin
                        ack_n = 1'b1;
                    end else if (!req) begin
                        ack_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Clear wins over a same-cycle increment; increments stop at all-ones
        ccnt_n = ccnt_q;
        ucnt_n = ucnt_q;
        if (clr_counts) begin
            ccnt_n = '0;
            ucnt_n = '0;
        end else begin
            if (inc_corr && (ccnt_q != CNT_MAX)) ccnt_n = ccnt_q + CNT_W'(1);
            if (inc_unc && (ucnt_q != CNT_MAX))  ucnt_n = ucnt_q + CNT_W'(1);
        end
    end

    assign ack               = ack_q;
    assign data_out          = data_q;
    assign err_corrected     = corr_q;
    assign err_uncorrectable = unc_q;
    assign corr_count        = ccnt_q;
    assign uncorr_count      = ucnt_q;

endmodule

// File: tb/tb_fec_secded_decoder.sv
// Directed and randomized bench for fec_secded_decoder.
// The reference decodes by nearest-codeword search over all 16 encodings.
module tb_fec_secded_decoder;

    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             req;
    logic [15:0]      data_in;
    logic             clr_counts;
    logic             ack;
    logic [7:0]       data_out;
    logic             err_corrected;
    logic             err_uncorrectable;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;

    int vectors = 0;
    int errors  = 0;
    int m_corr  = 0;
    int m_unc   = 0;

    fec_secded_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .data_in(data_in),
        .clr_counts(clr_counts), .ack(ack), .data_out(data_out),
        .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable),
        .corr_count(corr_count), .uncorr_count(uncorr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Codeword layout: bit i = Hamming position i, bit 0 = overall even parity
    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] cw;
        cw[3] = n[0];
        cw[5] = n[1];
        cw[6] = n[2];
        cw[7] = n[3];
        cw[1] = n[0] ^ n[1] ^ n[3];
        cw[2] = n[0] ^ n[2] ^ n[3];
        cw[4] = n[1] ^ n[2] ^ n[3];
        cw[0] = ^cw[7:1];
        return cw;
    endfunction

    task automatic ref_dec(input logic [7:0] cw, output logic [3:0] nib, output logic c, output logic u);
        int best = 9;
        logic [3:0] bn = 4'd0;
        for (int n = 0; n < 16; n++) begin
            int d = $countones(cw ^ enc(4'(n)));
            if (d < best) begin
                best = d;
                bn   = 4'(n);
            end
        end
        c   = (best == 1);
        u   = (best >= 2);
        nib = (best >= 2) ? {cw[7], cw[6], cw[5], cw[3]} : bn;
    endtask

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic make_cw(input int nerr, output logic [7:0] cw);
        int b1, b2;
        cw = enc(4'($urandom));
        b1 = $urandom_range(0, 7);
        b2 = (b1 + $urandom_range(1, 7)) % 8;
        if (nerr >= 1) cw = cw ^ (8'd1 << b1);
        if (nerr >= 2) cw = cw ^ (8'd1 << b2);
    endtask

    // One full transaction; optional en gap, clear during the low decode, and req held after ack
    task automatic send(input logic [15:0] d, input int gap, input bit clr_lo, input int hold);
        logic [3:0] nl, nh;
        logic       cl, ul, ch, uh;
        logic [7:0] exp_data;
        int         n;
        ref_dec(d[7:0], nl, cl, ul);
        ref_dec(d[15:8], nh, ch, uh);
        exp_data = {nh, nl};
        if (clr_lo) begin
            m_corr = 0;
            m_unc  = 0;
        end else begin
            m_corr = sat(m_corr + int'(cl));
            m_unc  = sat(m_unc + int'(ul));
        end
        m_corr = sat(m_corr + int'(ch));
        m_unc  = sat(m_unc + int'(uh));

        @(negedge clk);
        data_in = d;
        req     = 1'b1;
        n       = 0;
        while (n < 60) begin
            clr_counts = clr_lo && (n == 1);
            @(posedge clk);
            #1;
            n++;
            if (n == 1) data_in = 16'($urandom);
            if (clr_lo && n == 2) check("clr_priority", 32'(corr_count), 32'd0);
            en = !(n >= 1 && n <= gap);
            if (ack) break;
        end
        clr_counts = 1'b0;
        en         = 1'b1;
        check("latency", 32'(n), 32'(4 + gap));
        check("data_out", 32'(data_out), 32'(exp_data));
        check("err_corrected", 32'(err_corrected), 32'(cl | ch));
        check("err_uncorrectable", 32'(err_uncorrectable), 32'(ul | uh));
        check("corr_count", 32'(corr_count), 32'(m_corr));
        check("uncorr_count", 32'(uncorr_count), 32'(m_unc));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("ack_hold", 32'(ack), 32'd1);
            check("data_hold", 32'(data_out), 32'(exp_data));
        end
        if (hold > 0) check("single_decode", 32'(corr_count), 32'(m_corr));
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        check("ack_drop", 32'(ack), 32'd0);
        check("data_after_ack", 32'(data_out), 32'(exp_data));
    endtask

    initial begin
        logic [7:0] lo, hi;
        rst_n      = 1'b0;
        en         = 1'b1;
        req        = 1'b0;
        clr_counts = 1'b0;
        data_in    = 16'd0;
        #3;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_counts", 32'({corr_count, uncorr_count}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(16'hA55A, 0, 1'b0, 0);
        send(16'hA57A, 0, 1'b0, 0);
        send(16'hC55A, 0, 1'b0, 0);
        send(16'hA45A, 0, 1'b0, 0);
        send(16'hA57A, 0, 1'b1, 0);
        send(16'hA55A, 0, 1'b0, 10);
        send(16'hA57A, 5, 1'b0, 0);

        // Reset while the high codeword is being decoded
        @(negedge clk);
        data_in = 16'hA57A;
        req     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_data", 32'(data_out), 32'd0);
        check("midrst_flags", 32'({err_corrected, err_uncorrectable}), 32'd0);
        check("midrst_counts", 32'({corr_count, uncorr_count}), 32'd0);
        m_corr = 0;
        m_unc  = 0;
        req    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(16'hA57A, 0, 1'b0, 0);

        // Drive both counters into saturation
        for (int i = 0; i < 10; i++) begin
            make_cw(1, lo);
            make_cw(1, hi);
            send({hi, lo}, 0, 1'b0, 0);
        end
        check("corr_saturated", 32'(corr_count), 32'(CMAX));
        for (int i = 0; i < 10; i++) begin
            make_cw(2, lo);
            make_cw(2, hi);
            send({hi, lo}, 0, 1'b0, 0);
        end
        check("uncorr_saturated", 32'(uncorr_count), 32'(CMAX));

        // Random mix after a clean clear
        send(16'hA57A, 0, 1'b1, 0);
        for (int i = 0; i < 30; i++) begin
            make_cw($urandom_range(0, 2), lo);
            make_cw($urandom_range(0, 2), hi);
            send({hi, lo}, 0, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
